instr_encoder: RTL and testbench

//  Inverse of the instruction decoder: turns an op index (same 0..30 numbering as decoder op[] bits) plus

---
 rtl/mips31_isa_pkg.sv | 98 +++++++++
 rtl/instr_encode_comb.sv | 58 +++++
 rtl/instr_encoder.sv | 156 +++++++++++++++
 tb/tb_instr_encoder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips31_isa_pkg.sv
// Purpose: MIPS-31 ISA numbering shared by the instruction encoder and decoder
//          (op indices, primary opcodes, R-type functs) plus word-building helpers.
// Latency: n/a (constants and pure functions). Backpressure: n/a.
package mips31_isa_pkg;

  // Op indices: identical to decoder op[] bit positions.
  localparam logic [4:0] OP_ADDU    = 5'd0;
  localparam logic [4:0] OP_ADD     = 5'd1;
  localparam logic [4:0] OP_SUBU    = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_AND     = 5'd4;
  localparam logic [4:0] OP_OR      = 5'd5;
  localparam logic [4:0] OP_XOR     = 5'd6;
  localparam logic [4:0] OP_NOR     = 5'd7;
  localparam logic [4:0] OP_SLLV    = 5'd8;
  localparam logic [4:0] OP_SRLV    = 5'd9;
  localparam logic [4:0] OP_SRAV    = 5'd10;
  localparam logic [4:0] OP_SLT     = 5'd11;
  localparam logic [4:0] OP_SLTU    = 5'd12;
  localparam logic [4:0] OP_SLL     = 5'd13;
  localparam logic [4:0] OP_SRL     = 5'd14;
  localparam logic [4:0] OP_SRA     = 5'd15;
  localparam logic [4:0] OP_ADDI    = 5'd16;
  localparam logic [4:0] OP_ADDIU   = 5'd17;
  localparam logic [4:0] OP_ANDI    = 5'd18;
  localparam logic [4:0] OP_ORI     = 5'd19;
  localparam logic [4:0] OP_XORI    = 5'd20;
  localparam logic [4:0] OP_SLTI    = 5'd21;
  localparam logic [4:0] OP_SLTIU   = 5'd22;
  localparam logic [4:0] OP_LUI     = 5'd23;
  localparam logic [4:0] OP_LW      = 5'd24;
  localparam logic [4:0] OP_SW      = 5'd25;
  localparam logic [4:0] OP_BEQ     = 5'd26;
  localparam logic [4:0] OP_BNE     = 5'd27;
  localparam logic [4:0] OP_J       = 5'd28;
  localparam logic [4:0] OP_JAL     = 5'd29;
  localparam logic [4:0] OP_JR      = 5'd30;
  localparam logic [4:0] OP_ILLEGAL = 5'd31;

  // Primary opcodes.
  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_J       = 6'h02;
  localparam logic [5:0] OPC_JAL     = 6'h03;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_BNE     = 6'h05;
  localparam logic [5:0] OPC_ADDI    = 6'h08;
  localparam logic [5:0] OPC_ADDIU   = 6'h09;
  localparam logic [5:0] OPC_SLTI    = 6'h0A;
  localparam logic [5:0] OPC_SLTIU   = 6'h0B;
  localparam logic [5:0] OPC_ANDI    = 6'h0C;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_XORI    = 6'h0E;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_SW      = 6'h2B;

  // R-type function codes.
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    ENC_IDLE  = 2'd0,
    ENC_RUN   = 2'd1,
    ENC_DRAIN = 2'd2,
    ENC_DONE  = 2'd3
  } enc_state_t;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {OPC_SPECIAL, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] opc, input logic [25:0] target);
    return {opc, target};
  endfunction

endpackage

// File: rtl/instr_encode_comb.sv
// Purpose: pure combinational op index + operand fields -> 32-bit MIPS-31 word.
// Latency: 0 cycles. Backpressure: none (no state).
// Ports: op/rs/rt/rd/shamt/imm/target in; word out (0 when illegal), illegal out (op 31).
module instr_encode_comb
  import mips31_isa_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Fields an op does not use are passed as zero so stray operand bits never leak.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      OP_ADDU:  word = r_word(rs, rt, rd, 5'd0, FN_ADDU);
      OP_ADD:   word = r_word(rs, rt, rd, 5'd0, FN_ADD);
      OP_SUBU:  word = r_word(rs, rt, rd, 5'd0, FN_SUBU);
      OP_SUB:   word = r_word(rs, rt, rd, 5'd0, FN_SUB);
      OP_AND:   word = r_word(rs, rt, rd, 5'd0, FN_AND);
      OP_OR:    word = r_word(rs, rt, rd, 5'd0, FN_OR);
      OP_XOR:   word = r_word(rs, rt, rd, 5'd0, FN_XOR);
      OP_NOR:   word = r_word(rs, rt, rd, 5'd0, FN_NOR);
      OP_SLLV:  word = r_word(rs, rt, rd, 5'd0, FN_SLLV);
      OP_SRLV:  word = r_word(rs, rt, rd, 5'd0, FN_SRLV);
      OP_SRAV:  word = r_word(rs, rt, rd, 5'd0, FN_SRAV);
      OP_SLT:   word = r_word(rs, rt, rd, 5'd0, FN_SLT);
      OP_SLTU:  word = r_word(rs, rt, rd, 5'd0, FN_SLTU);
      OP_SLL:   word = r_word(5'd0, rt, rd, shamt, FN_SLL);
      OP_SRL:   word = r_word(5'd0, rt, rd, shamt, FN_SRL);
      OP_SRA:   word = r_word(5'd0, rt, rd, shamt, FN_SRA);
      OP_JR:    word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      OP_ADDI:  word = i_word(OPC_ADDI, rs, rt, imm);
      OP_ADDIU: word = i_word(OPC_ADDIU, rs, rt, imm);
      OP_ANDI:  word = i_word(OPC_ANDI, rs, rt, imm);
      OP_ORI:   word = i_word(OPC_ORI, rs, rt, imm);
      OP_XORI:  word = i_word(OPC_XORI, rs, rt, imm);
      OP_SLTI:  word = i_word(OPC_SLTI, rs, rt, imm);
      OP_SLTIU: word = i_word(OPC_SLTIU, rs, rt, imm);
      OP_LUI:   word = i_word(OPC_LUI, 5'd0, rt, imm);
      OP_LW:    word = i_word(OPC_LW, rs, rt, imm);
      OP_SW:    word = i_word(OPC_SW, rs, rt, imm);
      OP_BEQ:   word = i_word(OPC_BEQ, rs, rt, imm);
      OP_BNE:   word = i_word(OPC_BNE, rs, rt, imm);
      OP_J:     word = j_word(OPC_J, target);
      OP_JAL:   word = j_word(OPC_JAL, target);
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Purpose: streams encoded MIPS-31 words with sequential IMEM byte addresses to the loader.
// Latency: 1 cycle from input accept to out_valid; 1 word/cycle with out_ready held high.
// Backpressure: in_ready = ~out_valid | out_ready in RUN; output regs hold while stalled.
// Ports: clk, rst_n; start/base_addr begin a batch; in_* valid/ready field stream with in_last;
//        out_* valid/ready word stream with address and last flag; busy, done pulse,
//        sticky err_illegal, word_cnt of words emitted this batch.
module instr_encoder
  import mips31_isa_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic [CNT_W-1:0]  word_cnt
);

  enc_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_last_q, out_last_d;
  logic              err_illegal_q, err_illegal_d;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        in_acc;
  logic        out_hs;

  instr_encode_comb u_encode (
    .op      (in_op),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .imm     (in_imm),
    .target  (in_target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign out_hs   = out_valid_q & out_ready;
  assign in_ready = (state_q == ENC_RUN) & (~out_valid_q | out_ready);
  assign in_acc   = in_valid & in_ready;

  always_comb begin
    state_d       = state_q;
    err_illegal_d = err_illegal_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_addr_d    = out_addr_q;
    out_last_d    = out_last_q;

    // addr_cnt tracks the address of the oldest word not yet handed off,
    // so it advances only when the sink takes a word.
    addr_cnt_d = out_hs ? addr_cnt_q + ADDR_W'(ADDR_STEP) : addr_cnt_q;
    word_cnt_d = out_hs ? word_cnt_q + CNT_W'(1) : word_cnt_q;

    if (out_hs) begin
      out_valid_d = 1'b0;
    end
    if (in_acc) begin
      if (enc_illegal) begin
        err_illegal_d = 1'b1;
      end else begin
        // Using the post-handshake counter keeps back-to-back words sequential.
        out_valid_d = 1'b1;
        out_instr_d = enc_word;
        out_addr_d  = addr_cnt_d;
        out_last_d  = in_last;
      end
    end

    case (state_q)
      ENC_IDLE: begin
        if (start) begin
          state_d       = ENC_RUN;
          addr_cnt_d    = base_addr;
          word_cnt_d    = '0;
          err_illegal_d = 1'b0;
        end
      end
      ENC_RUN: begin
        if (in_acc && in_last) begin
          state_d = ENC_DRAIN;
        end
      end
      ENC_DRAIN: begin
        if (!out_valid_q || out_hs) begin
          state_d = ENC_DONE;
        end
      end
      ENC_DONE: begin
        state_d = ENC_IDLE;
      end
      default: begin
        state_d = ENC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ENC_IDLE;
      addr_cnt_q    <= '0;
      word_cnt_q    <= '0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_addr_q    <= '0;
      out_last_q    <= 1'b0;
      err_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_cnt_q    <= addr_cnt_d;
      word_cnt_q    <= word_cnt_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_addr_q    <= out_addr_d;
      out_last_q    <= out_last_d;
      err_illegal_q <= err_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_addr    = out_addr_q;
  assign out_last    = out_last_q;
  assign busy        = (state_q != ENC_IDLE);
  assign done        = (state_q == ENC_DONE);
  assign err_illegal = err_illegal_q;
  assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Purpose: self-checking bench for instr_encoder: directed scenarios plus a randomized
//          stream scored against a table-driven encoding model.
// Latency/backpressure: inputs driven on the falling edge, outputs sampled 1ns after it.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err_illegal;
  logic [15:0] word_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .out_last(out_last), .busy(busy), .done(done), .err_illegal(err_illegal),
    .word_cnt(word_cnt)
  );

  // Reference encoder: field placement by instruction class, codes from the ISA tables.
  function automatic logic [31:0] ref_encode(input int op, input int rs, input int rt,
                                             input int rd, input int sh, input int imm,
                                             input int tgt);
    logic [31:0] code;
    logic [31:0] r_s, r_t, r_d, s_h, im, tg;
    r_s = 32'(rs) & 32'h1F; r_t = 32'(rt) & 32'h1F; r_d = 32'(rd) & 32'h1F;
    s_h = 32'(sh) & 32'h1F; im = 32'(imm) & 32'hFFFF; tg = 32'(tgt) & 32'h3FFFFFF;
    code = 0;
    if (op <= 12) begin
      case (op)
        0: code = 'h21; 1: code = 'h20; 2: code = 'h23; 3: code = 'h22;
        4: code = 'h24; 5: code = 'h25; 6: code = 'h26; 7: code = 'h27;
        8: code = 'h04; 9: code = 'h06; 10: code = 'h07; 11: code = 'h2A;
        default: code = 'h2B;
      endcase
      return r_s * 32'h200000 + r_t * 32'h10000 + r_d * 32'h800 + code;
    end else if (op <= 15) begin
      code = (op == 13) ? 0 : (op == 14) ? 2 : 3;
      return r_t * 32'h10000 + r_d * 32'h800 + s_h * 32'h40 + code;
    end else if (op == 30) begin
      return r_s * 32'h200000 + 8;
    end else if (op <= 27) begin
      case (op)
        16: code = 'h08; 17: code = 'h09; 18: code = 'h0C; 19: code = 'h0D;
        20: code = 'h0E; 21: code = 'h0A; 22: code = 'h0B; 23: code = 'h0F;
        24: code = 'h23; 25: code = 'h2B; 26: code = 'h04; default: code = 'h05;
      endcase
      if (op == 23) r_s = 0;
      return code * 32'h4000000 + r_s * 32'h200000 + r_t * 32'h10000 + im;
    end else begin
      code = (op == 28) ? 2 : 3;
      return code * 32'h4000000 + tg;
    end
  endfunction

  task automatic put(input int op, input int rs, input int rt, input int rd, input int sh,
                     input int imm, input int tgt, input logic last);
    in_op = 5'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_shamt = 5'(sh);
    in_imm = 16'(imm); in_target = 26'(tgt); in_last = last; in_valid = 1'b1;
  endtask

  task automatic do_start(input logic [31:0] base);
    @(negedge clk); start = 1'b1; base_addr = base;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      if (done) seen = 1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL %s: done not seen within 20 cycles", name); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_instr, out_addr, out_last, busy, done, err_illegal, word_cnt, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b instr=%h addr=%h last=%b busy=%b done=%b err=%b cnt=%0d rdy=%b, all required 0",
               out_valid, out_instr, out_addr, out_last, busy, done, err_illegal, word_cnt, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    #1; n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b in_ready=%b required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic();
    do_start(32'h0);
    #1; n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL start_run: busy=%b in_ready=%b required 1 1", busy, in_ready);
    end
    put(0, 1, 2, 3, 0, 0, 0, 0); @(negedge clk); #1; n_checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00221821 || out_addr !== 32'h0) begin
      n_fail++; $display("FAIL addu: v=%b %h @%h required 1 00221821 @0", out_valid, out_instr, out_addr);
    end
    put(16, 1, 2, 0, 0, 'hFFFF, 0, 0); @(negedge clk); #1; n_checks++;
    if (out_instr !== 32'h2022FFFF || out_addr !== 32'h4) begin
      n_fail++; $display("FAIL addi: %h @%h required 2022FFFF @4", out_instr, out_addr);
    end
    put(13, 7, 2, 3, 4, 'h5A5A, 'h3FFFFFF, 0); @(negedge clk); #1; n_checks++;
    if (out_instr !== 32'h00021900 || out_addr !== 32'h8) begin
      n_fail++; $display("FAIL sll_mask: %h @%h required 00021900 @8", out_instr, out_addr);
    end
    put(24, 29, 8, 0, 0, 4, 0, 0); @(negedge clk); #1; n_checks++;
    if (out_instr !== 32'h8FA80004 || out_addr !== 32'hC) begin
      n_fail++; $display("FAIL lw: %h @%h required 8FA80004 @C", out_instr, out_addr);
    end
    put(28, 0, 0, 0, 0, 0, 'h100000, 1); @(negedge clk); #1; n_checks++;
    if (out_instr !== 32'h08100000 || out_addr !== 32'h10 || out_last !== 1'b1) begin
      n_fail++; $display("FAIL j_last: %h @%h last=%b required 08100000 @10 last=1", out_instr, out_addr, out_last);
    end
    in_valid = 1'b0;
    @(negedge clk); #1; n_checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || word_cnt !== 16'd5) begin
      n_fail++; $display("FAIL basic_done: done=%b v=%b cnt=%0d required 1 0 5", done, out_valid, word_cnt);
    end
    @(negedge clk); #1; n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_a, exp_b;
    exp_a = ref_encode(1, 4, 5, 6, 0, 0, 0);
    exp_b = ref_encode(19, 3, 4, 0, 0, 'h1234, 0);
    do_start(32'h100);
    put(1, 4, 5, 6, 0, 0, 0, 0); @(negedge clk);
    out_ready = 1'b0;
    put(19, 3, 4, 0, 0, 'h1234, 0, 1);
    for (int i = 0; i < 4; i++) begin
      #1; n_checks++;
      if (out_valid !== 1'b1 || out_instr !== exp_a || out_addr !== 32'h100 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: v=%b %h @%h rdy=%b required 1 %h @100 rdy=0",
                           i, out_valid, out_instr, out_addr, in_ready, exp_a);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk); #1; n_checks++;
    if (out_instr !== exp_b || out_addr !== 32'h104 || out_last !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: %h @%h last=%b required %h @104 last=1", out_instr, out_addr, out_last, exp_b);
    end
    in_valid = 1'b0;
    wait_done("stall_done");
  endtask

  task automatic test_illegal();
    logic [31:0] exp_w;
    exp_w = ref_encode(17, 2, 3, 0, 0, 'h8000, 0);
    do_start(32'h40);
    put(0, 9, 9, 9, 0, 0, 0, 0); @(negedge clk);
    put(31, 1, 2, 3, 4, 'hFFFF, 'h1234, 0); @(negedge clk); #1; n_checks++;
    if (out_valid !== 1'b0 || err_illegal !== 1'b1) begin
      n_fail++; $display("FAIL illegal_flag: v=%b err=%b required 0 1", out_valid, err_illegal);
    end
    put(17, 2, 3, 0, 0, 'h8000, 0, 1); @(negedge clk); #1; n_checks++;
    if (out_instr !== exp_w || out_addr !== 32'h44 || err_illegal !== 1'b1) begin
      n_fail++; $display("FAIL illegal_addr: %h @%h err=%b required %h @44 err=1", out_instr, out_addr, err_illegal, exp_w);
    end
    in_valid = 1'b0;
    wait_done("illegal_done");
    do_start(32'h80);
    #1; n_checks++;
    if (err_illegal !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: err=%b required 0", err_illegal);
    end
    put(5, 1, 1, 1, 0, 0, 0, 1); @(negedge clk); in_valid = 1'b0;
    wait_done("err_clear_done");
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w;
    exp_w = ref_encode(29, 0, 0, 0, 0, 0, 'h2ABCDEF);
    do_start(32'hFFFFFFFC);
    put(2, 1, 2, 3, 0, 0, 0, 0); @(negedge clk); #1; n_checks++;
    if (out_addr !== 32'hFFFFFFFC || out_last !== 1'b0) begin
      n_fail++; $display("FAIL wrap_first: @%h last=%b required @FFFFFFFC last=0", out_addr, out_last);
    end
    put(29, 0, 0, 0, 0, 0, 'h2ABCDEF, 1); @(negedge clk); #1; n_checks++;
    if (out_addr !== 32'h0 || out_last !== 1'b1 || out_instr !== exp_w) begin
      n_fail++; $display("FAIL wrap_second: %h @%h last=%b required %h @0 last=1", out_instr, out_addr, out_last, exp_w);
    end
    in_valid = 1'b0;
    @(negedge clk); #1; n_checks++;
    if (done !== 1'b1 || word_cnt !== 16'd2) begin
      n_fail++; $display("FAIL wrap_done: done=%b cnt=%0d required 1 2", done, word_cnt);
    end
    @(negedge clk); #1; n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse: done=%b on second cycle, required 0", done);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_w;
    bit saw_done = 0;
    exp_w = ref_encode(6, 10, 11, 12, 0, 0, 0);
    do_start(32'h200);
    put(4, 1, 2, 3, 0, 0, 0, 0); @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1; n_checks++;
    if ({out_valid, out_instr, out_addr, out_last, busy, done, err_illegal, word_cnt, in_ready} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: v=%b %h @%h busy=%b cnt=%0d, all required 0",
                         out_valid, out_instr, out_addr, busy, word_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (done) saw_done = 1;
    end
    n_checks++;
    if (saw_done) begin n_fail++; $display("FAIL midreset_no_done: done=1 seen, required 0"); end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    do_start(32'h300);
    put(6, 10, 11, 12, 0, 0, 0, 1); @(negedge clk); #1; n_checks++;
    if (out_instr !== exp_w || out_addr !== 32'h300 || word_cnt !== 16'd0) begin
      n_fail++; $display("FAIL post_reset: %h @%h cnt=%0d required %h @300 cnt=0", out_instr, out_addr, word_cnt, exp_w);
    end
    in_valid = 1'b0;
    wait_done("post_reset_done");
  endtask

  task automatic test_random();
    logic [64:0] exp_q[$];
    logic [64:0] e;
    logic [31:0] model_addr, base;
    int n_in = 150, idx = 0, legal = 0;
    int op, rs, rt, rd, sh, imm, tgt;
    bit acc_prev = 0, seen_done = 0;
    base = $urandom() & 32'hFFFFFFFC;
    model_addr = base;
    do_start(base);
    for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (acc_prev) in_valid = 1'b0;
      acc_prev = 0;
      out_ready = ($urandom_range(0, 9) < 7);
      if (!in_valid && idx < n_in && $urandom_range(0, 3) != 0) begin
        op = ($urandom_range(0, 15) == 0) ? 31 : $urandom_range(0, 30);
        rs = $urandom_range(0, 31); rt = $urandom_range(0, 31); rd = $urandom_range(0, 31);
        sh = $urandom_range(0, 31); imm = $urandom_range(0, 65535); tgt = $urandom_range(0, 32'h3FFFFFF);
        put(op, rs, rt, rd, sh, imm, tgt, idx == n_in - 1);
      end
      #1;
      if (in_valid && in_ready) begin
        acc_prev = 1; idx++;
        if (op != 31) begin
          exp_q.push_back({in_last, model_addr, ref_encode(op, rs, rt, rd, sh, imm, tgt)});
          model_addr += 4; legal++;
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra: unexpected word %h @%h", out_instr, out_addr);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_addr, out_instr} !== e) begin
            n_fail++; $display("FAIL rand_word: last=%b @%h %h required last=%b @%h %h",
                               out_last, out_addr, out_instr, e[64], e[63:32], e[31:0]);
          end
        end
      end
      if (done) begin
        seen_done = 1;
        n_checks++;
        if (exp_q.size() != 0 || word_cnt !== 16'(legal)) begin
          n_fail++; $display("FAIL rand_done: pending=%0d cnt=%0d required 0 %0d", exp_q.size(), word_cnt, legal);
        end
      end
    end
    n_checks++;
    if (!seen_done) begin n_fail++; $display("FAIL rand_timeout: done not reached, %0d inputs sent", idx); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_imm = '0; in_target = '0; in_last = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_illegal();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
